// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack CPU control block: FSM states,
// instruction field positions and default widths.
package hack_pkg;

  localparam int unsigned DefWidth  = 16;
  localparam int unsigned DefAwidth = 15;

  localparam int unsigned IrTypeBit = 15;
  localparam int unsigned IrABit    = 12;
  localparam int unsigned IrCompHi  = 11;
  localparam int unsigned IrCompLo  = 6;
  localparam int unsigned IrDestA   = 5;
  localparam int unsigned IrDestD   = 4;
  localparam int unsigned IrDestM   = 3;
  localparam int unsigned IrJumpHi  = 2;
  localparam int unsigned IrJumpLo  = 0;

  typedef enum logic {
    StIdle = 1'b0,
    StExec = 1'b1
  } state_e;

endpackage

// File: rtl/hack_jump_cond.sv
// Jump-condition decode: j1 selects negative, j2 zero, j3 positive results.
module hack_jump_cond (
  input  logic [2:0] i_jump,
  input  logic       i_zr,
  input  logic       i_ng,
  output logic       o_take
);

  assign o_take = (i_jump[2] & i_ng) | (i_jump[1] & i_zr) | (i_jump[0] & ~i_ng & ~i_zr);

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Hack CPU control: fetches one instruction per two cycles, drives the external
// ALU and memory port, and holds the A, D and PC registers.
module hack_cpu_ctrl
  import hack_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned AWIDTH = DefAwidth
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [WIDTH-1:0]  instr,
  output logic              instr_ready,
  input  logic [WIDTH-1:0]  in_m,
  output logic [WIDTH-1:0]  alu_x,
  output logic [WIDTH-1:0]  alu_y,
  output logic [5:0]        alu_ctrl,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic [WIDTH-1:0]  out_m,
  output logic              write_m,
  output logic [AWIDTH-1:0] address_m,
  output logic [AWIDTH-1:0] pc
);

  state_e             r_state;
  state_e             w_state_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_d;
  logic [WIDTH-1:0]   r_ir;
  logic [AWIDTH-1:0]  r_pc;
  logic [AWIDTH-1:0]  w_pc_inc;
  logic               w_accept;
  logic               w_exec;
  logic               w_is_c;
  logic               w_take;

  assign w_accept = instr_valid && instr_ready;
  assign w_exec   = (r_state == StExec);
  assign w_is_c   = r_ir[IrTypeBit];
  assign w_pc_inc = r_pc + {{(AWIDTH-1){1'b0}}, 1'b1};

  hack_jump_cond u_jump_cond (
    .i_jump (r_ir[IrJumpHi:IrJumpLo]),
    .i_zr   (alu_zr),
    .i_ng   (alu_ng),
    .o_take (w_take)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StExec;
      StExec:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // ALU operands stay live in IDLE; only the control word and strobe are gated.
  always_comb begin
    instr_ready = (r_state == StIdle);
    alu_x       = r_d;
    alu_y       = r_ir[IrABit] ? in_m : r_a;
    alu_ctrl    = 6'b000000;
    write_m     = 1'b0;
    out_m       = alu_out;
    address_m   = r_a[AWIDTH-1:0];
    pc          = r_pc;
    if (w_exec && w_is_c) begin
      alu_ctrl = r_ir[IrCompHi:IrCompLo];
      write_m  = r_ir[IrDestM];
    end
  end

  // Non-blocking updates make a taken jump see A from before any same-cycle A load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a  <= '0;
      r_d  <= '0;
      r_ir <= '0;
      r_pc <= '0;
    end else begin
      if (w_accept) begin
        r_ir <= instr;
      end
      if (w_exec) begin
        if (!w_is_c) begin
          r_a  <= {1'b0, r_ir[WIDTH-2:0]};
          r_pc <= w_pc_inc;
        end else begin
          if (r_ir[IrDestA]) r_a <= alu_out;
          if (r_ir[IrDestD]) r_d <= alu_out;
          r_pc <= w_take ? r_a[AWIDTH-1:0] : w_pc_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Directed bench for hack_cpu_ctrl with a behavioural Hack ALU model.
module tb_hack_cpu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [15:0] in_m;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [5:0]  alu_ctrl;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;
  logic [15:0] out_m;
  logic        write_m;
  logic [14:0] address_m;
  logic [14:0] pc;

  int total = 0;
  int bad   = 0;

  hack_cpu_ctrl #(.WIDTH(16), .AWIDTH(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .in_m        (in_m),
    .alu_x       (alu_x),
    .alu_y       (alu_y),
    .alu_ctrl    (alu_ctrl),
    .alu_out     (alu_out),
    .alu_zr      (alu_zr),
    .alu_ng      (alu_ng),
    .out_m       (out_m),
    .write_m     (write_m),
    .address_m   (address_m),
    .pc          (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
    logic [15:0] xx, yy, r;
    xx = c[5] ? 16'h0000 : x;
    xx = c[4] ? ~xx : xx;
    yy = c[3] ? 16'h0000 : y;
    yy = c[2] ? ~yy : yy;
    r  = c[1] ? (xx + yy) : (xx & yy);
    r  = c[0] ? ~r : r;
    return r;
  endfunction

  assign alu_out = hack_alu(alu_x, alu_y, alu_ctrl);
  assign alu_zr  = (alu_out == 16'h0000);
  assign alu_ng  = alu_out[15];

  // Offer one instruction and return #1 after the accepting edge (inside EXEC).
  task automatic send(input logic [15:0] ins);
    int n;
    n = 0;
    while (instr_ready !== 1'b1 && n < 4) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (instr_ready !== 1'b1) begin
      $display("FAIL send_ready got=%b want=1", instr_ready);
      bad++;
    end
    instr       = ins;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic commit();
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [15:0] ins);
    send(ins);
    commit();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (pc !== 15'h0000) begin $display("FAIL rst_pc got=%h want=0000", pc); bad++; end
    total++; if (address_m !== 15'h0000) begin $display("FAIL rst_a got=%h want=0000", address_m); bad++; end
    total++; if (alu_x !== 16'h0000) begin $display("FAIL rst_d got=%h want=0000", alu_x); bad++; end
    total++; if (instr_ready !== 1'b1) begin $display("FAIL rst_ready got=%b want=1", instr_ready); bad++; end
    total++; if (write_m !== 1'b0) begin $display("FAIL rst_wm got=%b want=0", write_m); bad++; end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_d();
    run(16'h0011);
    total++; if (address_m !== 15'h0011) begin $display("FAIL ld_a got=%h want=0011", address_m); bad++; end
    send(16'hEC10);
    total++; if (alu_ctrl !== 6'b110000) begin $display("FAIL ld_ctrl got=%b want=110000", alu_ctrl); bad++; end
    total++; if (instr_ready !== 1'b0) begin $display("FAIL ld_busy got=%b want=0", instr_ready); bad++; end
    commit();
    total++; if (alu_x !== 16'h0011) begin $display("FAIL ld_d got=%h want=0011", alu_x); bad++; end
    total++; if (pc !== 15'h0002) begin $display("FAIL ld_pc got=%h want=0002", pc); bad++; end
    total++; if (alu_ctrl !== 6'b000000) begin $display("FAIL idle_ctrl got=%b want=000000", alu_ctrl); bad++; end
  endtask

  task automatic test_add();
    run(16'h0003);
    send(16'hE090);
    total++; if (alu_ctrl !== 6'b000010) begin $display("FAIL add_ctrl got=%b want=000010", alu_ctrl); bad++; end
    commit();
    total++; if (alu_x !== 16'h0014) begin $display("FAIL add_d got=%h want=0014", alu_x); bad++; end
    total++; if (pc !== 15'h0004) begin $display("FAIL add_pc got=%h want=0004", pc); bad++; end
  endtask

  task automatic test_mem_write();
    run(16'h0005);
    total++; if (write_m !== 1'b0) begin $display("FAIL wr_pre got=%b want=0", write_m); bad++; end
    send(16'hE308);
    total++; if (write_m !== 1'b1) begin $display("FAIL wr_strobe got=%b want=1", write_m); bad++; end
    total++; if (address_m !== 15'h0005) begin $display("FAIL wr_addr got=%h want=0005", address_m); bad++; end
    total++; if (out_m !== 16'h0014) begin $display("FAIL wr_data got=%h want=0014", out_m); bad++; end
    commit();
    total++; if (write_m !== 1'b0) begin $display("FAIL wr_post got=%b want=0", write_m); bad++; end
    total++; if (pc !== 15'h0006) begin $display("FAIL wr_pc got=%h want=0006", pc); bad++; end
  endtask

  task automatic test_mem_read();
    in_m = 16'h1234;
    send(16'hFC10);
    total++; if (alu_y !== 16'h1234) begin $display("FAIL rd_y got=%h want=1234", alu_y); bad++; end
    commit();
    total++; if (alu_x !== 16'h1234) begin $display("FAIL rd_d got=%h want=1234", alu_x); bad++; end
    total++; if (pc !== 15'h0007) begin $display("FAIL rd_pc got=%h want=0007", pc); bad++; end
  endtask

  task automatic test_jump();
    run(16'h0020);
    run(16'hEA90);
    run(16'hE302);
    total++; if (pc !== 15'h0020) begin $display("FAIL jeq_take got=%h want=0020", pc); bad++; end
    run(16'hEFD0);
    run(16'hE302);
    total++; if (pc !== 15'h0022) begin $display("FAIL jeq_skip got=%h want=0022", pc); bad++; end
    // 0;JMP with dest A: jump target must be A before this instruction's write.
    send(16'hEAA7);
    total++; if (address_m !== 15'h0020) begin $display("FAIL jmp_a_exec got=%h want=0020", address_m); bad++; end
    commit();
    total++; if (pc !== 15'h0020) begin $display("FAIL jmp_olda got=%h want=0020", pc); bad++; end
    total++; if (address_m !== 15'h0000) begin $display("FAIL jmp_newa got=%h want=0000", address_m); bad++; end
  endtask

  task automatic test_pc_wrap();
    run(16'h7FFF);
    run(16'hEA87);
    total++; if (pc !== 15'h7FFF) begin $display("FAIL wrap_setup got=%h want=7fff", pc); bad++; end
    run(16'hEC10);
    total++; if (pc !== 15'h0000) begin $display("FAIL wrap_pc got=%h want=0000", pc); bad++; end
    total++; if (alu_x !== 16'h7FFF) begin $display("FAIL wrap_d got=%h want=7fff", alu_x); bad++; end
  endtask

  task automatic test_back_to_back();
    logic [5:0] seen;
    logic [5:0] want;
    want = 6'b101010;
    instr       = 16'h0001;
    instr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      seen[i] = instr_ready;
    end
    instr_valid = 1'b0;
    total++; if (seen !== want) begin $display("FAIL b2b_ready got=%b want=%b", seen, want); bad++; end
    total++; if (pc !== 15'h0003) begin $display("FAIL b2b_pc got=%h want=0003", pc); bad++; end
  endtask

  task automatic test_reset_mid_exec();
    send(16'h0011);
    rst_n = 1'b0;
    #1;
    total++; if (alu_x !== 16'h0000) begin $display("FAIL mid_d got=%h want=0000", alu_x); bad++; end
    total++; if (address_m !== 15'h0000) begin $display("FAIL mid_a got=%h want=0000", address_m); bad++; end
    total++; if (pc !== 15'h0000) begin $display("FAIL mid_pc got=%h want=0000", pc); bad++; end
    total++; if (instr_ready !== 1'b1) begin $display("FAIL mid_ready got=%b want=1", instr_ready); bad++; end
    total++; if (write_m !== 1'b0) begin $display("FAIL mid_wm got=%b want=0", write_m); bad++; end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(16'h0009);
    send(16'hEFC8);
    total++; if (write_m !== 1'b1) begin $display("FAIL cut_pre got=%b want=1", write_m); bad++; end
    rst_n = 1'b0;
    #1;
    total++; if (write_m !== 1'b0) begin $display("FAIL cut_wm got=%b want=0", write_m); bad++; end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    instr_valid = 1'b0;
    instr       = 16'h0000;
    in_m        = 16'h0000;
    rst_n       = 1'b1;
    test_reset();
    test_load_d();
    test_add();
    test_mem_write();
    test_mem_read();
    test_jump();
    test_pc_wrap();
    test_reset();
    test_back_to_back();
    test_reset_mid_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
